// File: rtl/conv_pkg.sv
// Shared constants, TUSER bit positions and the generator state type for the
// conv-engine column front end.
package conv_pkg;

  localparam int KERNEL_W_MAX = 7;
  localparam int COLS_MAX     = 512;
  localparam int BLOCKS_MAX   = 256;
  localparam int TUSER_WIDTH  = 4;

  localparam int INDEX_IS_1x1       = 0;
  localparam int INDEX_IS_COL_0     = 1;
  localparam int INDEX_IS_COL_LAST  = 2;
  localparam int INDEX_IS_COLS_1_K2 = 3;

  localparam int KW_W  = $clog2(KERNEL_W_MAX + 1);
  localparam int COL_W = $clog2(COLS_MAX);
  localparam int BLK_W = $clog2(BLOCKS_MAX);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/conv_user_flags.sv
// Combinational map from column/block position and layer config to the TUSER
// flags and last marker consumed by the pad filter.
module conv_user_flags
  import conv_pkg::*;
(
  input  logic [COL_W-1:0]       col,
  input  logic [COL_W-1:0]       cols_1,
  input  logic [KW_W-1:0]        kernel_w_1,
  input  logic                   is_1x1,
  input  logic [BLK_W-1:0]       blk,
  input  logic [BLK_W-1:0]       blocks_1,
  output logic [TUSER_WIDTH-1:0] m_user,
  output logic                   m_last
);

  logic [COL_W-1:0] kw2;

  // Half kernel width, widened to the column width for the compare below.
  always_comb begin
    kw2 = COL_W'(kernel_w_1 >> 1);
  end

  // Flag decode; the >= guard keeps cols_1 - kw2 from wrapping.
  always_comb begin
    m_user                     = '0;
    m_user[INDEX_IS_1x1]       = is_1x1;
    m_user[INDEX_IS_COL_0]     = (col == '0);
    m_user[INDEX_IS_COL_LAST]  = (col == cols_1);
    m_user[INDEX_IS_COLS_1_K2] = !is_1x1 && (cols_1 >= kw2) && (col == (cols_1 - kw2));
    m_last                     = (col == cols_1) && (blk == blocks_1);
  end

endmodule

// File: rtl/conv_user_gen.sv
// Emits one flagged beat per output column for every row block of a layer,
// with registered AXI-stream-style outputs and a done pulse at the end.
module conv_user_gen
  import conv_pkg::*;
(
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   aclken,
  input  logic                   start,
  input  logic [KW_W-1:0]        kernel_w_1_in,
  input  logic                   is_1x1_in,
  input  logic [COL_W-1:0]       cols_1_in,
  input  logic [BLK_W-1:0]       blocks_1_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [TUSER_WIDTH-1:0] m_user,
  output logic                   m_last,
  output logic                   busy,
  output logic                   done
);

  state_t           state;
  logic [COL_W-1:0] col;
  logic [BLK_W-1:0] blk;
  logic [KW_W-1:0]  kernel_w_1;
  logic             is_1x1;
  logic [COL_W-1:0] cols_1;
  logic [BLK_W-1:0] blocks_1;

  logic [COL_W-1:0]       next_col;
  logic [BLK_W-1:0]       next_blk;
  logic [KW_W-1:0]        sel_kernel_w_1;
  logic                   sel_is_1x1;
  logic [COL_W-1:0]       sel_cols_1;
  logic [BLK_W-1:0]       sel_blocks_1;
  logic [TUSER_WIDTH-1:0] next_user;
  logic                   next_last;

  // Next position and the config it is evaluated against; in IDLE the first
  // beat must be decoded from the incoming config before it is latched.
  always_comb begin
    next_col       = '0;
    next_blk       = '0;
    sel_kernel_w_1 = kernel_w_1;
    sel_is_1x1     = is_1x1;
    sel_cols_1     = cols_1;
    sel_blocks_1   = blocks_1;
    if (state == IDLE) begin
      sel_kernel_w_1 = kernel_w_1_in;
      sel_is_1x1     = is_1x1_in;
      sel_cols_1     = cols_1_in;
      sel_blocks_1   = blocks_1_in;
    end else begin
      if (col == cols_1) begin
        next_col = '0;
        next_blk = blk + BLK_W'(1);
      end else begin
        next_col = col + COL_W'(1);
        next_blk = blk;
      end
    end
  end

  conv_user_flags u_flags (
    .col        (next_col),
    .cols_1     (sel_cols_1),
    .kernel_w_1 (sel_kernel_w_1),
    .is_1x1     (sel_is_1x1),
    .blk        (next_blk),
    .blocks_1   (sel_blocks_1),
    .m_user     (next_user),
    .m_last     (next_last)
  );

  // Control FSM with registered stream outputs; everything frozen when aclken is low.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      col        <= '0;
      blk        <= '0;
      kernel_w_1 <= '0;
      is_1x1     <= 1'b0;
      cols_1     <= '0;
      blocks_1   <= '0;
      m_valid    <= 1'b0;
      m_user     <= '0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (aclken) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            kernel_w_1 <= kernel_w_1_in;
            is_1x1     <= is_1x1_in;
            cols_1     <= cols_1_in;
            blocks_1   <= blocks_1_in;
            col        <= '0;
            blk        <= '0;
            m_valid    <= 1'b1;
            m_user     <= next_user;
            m_last     <= next_last;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (m_valid && m_ready) begin
            if (m_last) begin
              state   <= IDLE;
              m_valid <= 1'b0;
              m_user  <= '0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              col    <= next_col;
              blk    <= next_blk;
              m_user <= next_user;
              m_last <= next_last;
            end
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_user_gen.sv
// Directed bench for conv_user_gen: a reference model pushes expected beats
// when a start is issued and a negedge monitor pops them on each handshake.
module tb_conv_user_gen;
  import conv_pkg::*;

  typedef struct packed {
    logic [TUSER_WIDTH-1:0] user;
    logic                   last;
  } beat_t;

  logic                   aclk;
  logic                   aresetn;
  logic                   aclken;
  logic                   start;
  logic [KW_W-1:0]        kernel_w_1_in;
  logic                   is_1x1_in;
  logic [COL_W-1:0]       cols_1_in;
  logic [BLK_W-1:0]       blocks_1_in;
  logic                   m_valid;
  logic                   m_ready;
  logic [TUSER_WIDTH-1:0] m_user;
  logic                   m_last;
  logic                   busy;
  logic                   done;

  beat_t q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  logic  exp_busy = 1'b0;
  logic  exp_done = 1'b0;

  conv_user_gen dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .aclken        (aclken),
    .start         (start),
    .kernel_w_1_in (kernel_w_1_in),
    .is_1x1_in     (is_1x1_in),
    .cols_1_in     (cols_1_in),
    .blocks_1_in   (blocks_1_in),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_user        (m_user),
    .m_last        (m_last),
    .busy          (busy),
    .done          (done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input logic ok, input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (ok === 1'b1) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference model: full beat sequence of one layer.
  task automatic push_layer(input int kw, input bit is1, input int cols, input int blks);
    beat_t b;
    for (int bk = 0; bk <= blks; bk++) begin
      for (int c = 0; c <= cols; c++) begin
        b.user    = '0;
        b.user[0] = is1;
        b.user[1] = (c == 0);
        b.user[2] = (c == cols);
        b.user[3] = !is1 && (cols >= kw / 2) && (c == cols - kw / 2);
        b.last    = (c == cols) && (bk == blks);
        q.push_back(b);
      end
    end
  endtask

  task automatic start_layer(input int kw, input bit is1, input int cols, input int blks, input bit accepted);
    kernel_w_1_in = KW_W'(kw);
    is_1x1_in     = is1;
    cols_1_in     = COL_W'(cols);
    blocks_1_in   = BLK_W'(blks);
    if (accepted) push_layer(kw, is1, cols, blks);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
  task automatic run_until_done(input int mode, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      m_ready = (mode == 0) ? 1'b1 : ((i % 3) == 0);
      tick();
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(seen, {tag, "_done_seen"}, 32'(seen), 32'd1);
    chk(q.size() == 0, {tag, "_sb_drained"}, 32'(q.size()), 32'd0);
  endtask

  // Monitor: compare outputs against the model, pop on handshake, advance model state.
  always @(negedge aclk) begin
    logic  hs;
    beat_t exp_b;
    hs = aresetn && aclken && m_valid && m_ready;
    chk(m_valid === exp_busy, "m_valid", 32'(m_valid), 32'(exp_busy));
    chk(busy === exp_busy, "busy", 32'(busy), 32'(exp_busy));
    chk(done === exp_done, "done", 32'(done), 32'(exp_done));
    exp_b = '0;
    if (exp_busy) begin
      if (q.size() > 0) exp_b = q[0];
      else chk(1'b0, "sb_empty", 32'(m_valid), 32'd0);
    end
    chk(m_user === exp_b.user, "m_user", 32'(m_user), 32'(exp_b.user));
    chk(m_last === exp_b.last, "m_last", 32'(m_last), 32'(exp_b.last));
    if (!aresetn) begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else if (aclken) begin
      exp_done = 1'b0;
      if (exp_busy) begin
        if (hs && exp_b.last) begin
          exp_busy = 1'b0;
          exp_done = 1'b1;
        end
      end else if (start) begin
        exp_busy = 1'b1;
      end
    end
    if (hs && q.size() > 0) void'(q.pop_front());
  end

  initial begin
    aresetn       = 1'b0;
    aclken        = 1'b1;
    start         = 1'b0;
    m_ready       = 1'b0;
    kernel_w_1_in = '0;
    is_1x1_in     = 1'b0;
    cols_1_in     = '0;
    blocks_1_in   = '0;
    repeat (3) tick();
    chk(busy === 1'b0, "reset_busy", 32'(busy), 32'd0);
    chk(m_valid === 1'b0, "reset_valid", 32'(m_valid), 32'd0);
    aresetn = 1'b1;
    tick();

    // 8 beats back to back, then with ready stalls
    m_ready = 1'b1;
    start_layer(4, 1'b0, 7, 0, 1'b1);
    run_until_done(0, "k5_c8");
    tick();
    start_layer(4, 1'b0, 7, 0, 1'b1);
    run_until_done(1, "k5_c8_stall");
    tick();

    // 1x1 kernel over three row blocks
    m_ready = 1'b1;
    start_layer(0, 1'b1, 3, 2, 1'b1);
    run_until_done(0, "k1_c4_b3");
    tick();

    // widest row, counters must not overflow
    start_layer(6, 1'b0, COLS_MAX - 1, 0, 1'b1);
    run_until_done(0, "cmax");
    tick();

    // single-beat layer, ignored restart, start on the done cycle
    start_layer(0, 1'b0, 0, 0, 1'b1);
    m_ready = 1'b0;
    start_layer(4, 1'b0, 5, 3, 1'b0);
    m_ready = 1'b1;
    tick();
    chk(done === 1'b1, "single_done", 32'(done), 32'd1);
    start_layer(6, 1'b0, 2, 1, 1'b1);
    run_until_done(0, "k7_c3");
    tick();

    // clock-enable freeze mid-layer, then reset abort
    m_ready = 1'b1;
    start_layer(2, 1'b0, 4, 1, 1'b1);
    repeat (3) tick();
    aclken = 1'b0;
    repeat (3) tick();
    aclken = 1'b1;
    repeat (2) tick();
    aresetn = 1'b0;
    tick();
    q.delete();
    aresetn = 1'b1;
    repeat (3) tick();
    chk(busy === 1'b0, "abort_busy", 32'(busy), 32'd0);
    chk(done === 1'b0, "abort_done", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
